// File: rtl/st_arb_pkg.sv
// Shared state encoding and default sizing for the two-source burst arbiter.
package st_arb_pkg;

  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefBurstLen = 16;

  // One-hot encoding so the state register drives the grant port directly.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrant0 = 2'b01,
    StGrant1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry FIFO between the arbiter and the merged stream.
// Full and empty are registered so upstream ready never depends on downstream ready.
module st_skid_buffer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              full_q;
  logic              empty_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      full_q  <= (count_d == 2'd2);
      empty_q <= (count_d == 2'd0);
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/st_burst_arbiter.sv
// Two-source streaming arbiter: grants whole bursts of up to BURST_LEN beats,
// alternating on ties, and merges them through a two-entry skid buffer.
module st_burst_arbiter
  import st_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned BURST_LEN = DefBurstLen
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              asi0_valid,
  input  logic [DATA_W-1:0] asi0_data,
  output logic              asi0_ready,
  input  logic              asi1_valid,
  input  logic [DATA_W-1:0] asi1_data,
  output logic              asi1_ready,
  output logic              aso_valid,
  output logic [DATA_W-1:0] aso_data,
  input  logic              aso_ready,
  output logic [1:0]        grant
);

  localparam int unsigned     CntW     = $clog2(BURST_LEN + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

  arb_state_e        state_q;
  logic [CntW-1:0]   cnt_q;
  logic              last_grant_q;  // index of the source whose burst ended most recently
  logic              buf_full;
  logic              buf_empty;
  logic              accept0;
  logic              accept1;
  logic              end0;
  logic              end1;
  logic              push;
  logic [DATA_W-1:0] push_data;

  assign grant      = state_q;
  assign asi0_ready = (state_q == StGrant0) && !buf_full;
  assign asi1_ready = (state_q == StGrant1) && !buf_full;
  assign accept0    = asi0_valid && asi0_ready;
  assign accept1    = asi1_valid && asi1_ready;

  // A burst closes on its last beat or as soon as the owner stops offering data.
  assign end0 = !asi0_valid || (accept0 && (cnt_q == LastBeat));
  assign end1 = !asi1_valid || (accept1 && (cnt_q == LastBeat));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (asi0_valid && asi1_valid) begin
            state_q <= last_grant_q ? StGrant0 : StGrant1;
          end else if (asi0_valid) begin
            state_q <= StGrant0;
          end else if (asi1_valid) begin
            state_q <= StGrant1;
          end
        end
        StGrant0: begin
          if (end0) begin
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            if (asi1_valid) begin
              state_q <= StGrant1;
            end else if (asi0_valid) begin
              state_q <= StGrant0;
            end else begin
              state_q <= StIdle;
            end
          end else if (accept0) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StGrant1: begin
          if (end1) begin
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            if (asi0_valid) begin
              state_q <= StGrant0;
            end else if (asi1_valid) begin
              state_q <= StGrant1;
            end else begin
              state_q <= StIdle;
            end
          end else if (accept1) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign push      = accept0 || accept1;
  assign push_data = accept1 ? asi1_data : asi0_data;

  st_skid_buffer #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (aso_ready),
    .head_data (aso_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign aso_valid = !buf_empty;

endmodule

// File: tb/tb_st_burst_arbiter.sv
// Scoreboard bench: directed source streams push hand-ordered expected beats; monitors
// on each output stream pop and compare on every delivered beat.
module tb_st_burst_arbiter;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  // [instance][source]; instance 0 has BURST_LEN 16, instance 1 has BURST_LEN 1
  logic          sv   [2][2];
  logic [DW-1:0] sd   [2][2];
  logic [DW-1:0] base [2][2];
  int unsigned   sent [2][2];
  int unsigned   lim  [2][2];
  int            first_acc [2];
  int            last_acc  [2];

  logic a_rdy0, a_rdy1, a_ov, a_ordy;
  logic b_rdy0, b_rdy1, b_ov, b_ordy;
  logic [DW-1:0] a_od, b_od;
  logic [1:0] a_gnt, b_gnt;
  logic ov_pre_a;

  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  st_burst_arbiter #(.DATA_W(DW), .BURST_LEN(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .asi0_valid(sv[0][0]), .asi0_data(sd[0][0]), .asi0_ready(a_rdy0),
    .asi1_valid(sv[0][1]), .asi1_data(sd[0][1]), .asi1_ready(a_rdy1),
    .aso_valid(a_ov), .aso_data(a_od), .aso_ready(a_ordy), .grant(a_gnt)
  );

  st_burst_arbiter #(.DATA_W(DW), .BURST_LEN(1)) u_dut_b1 (
    .clk(clk), .reset_n(reset_n),
    .asi0_valid(sv[1][0]), .asi0_data(sd[1][0]), .asi0_ready(b_rdy0),
    .asi1_valid(sv[1][1]), .asi1_data(sd[1][1]), .asi1_ready(b_rdy1),
    .aso_valid(b_ov), .aso_data(b_od), .aso_ready(b_ordy), .grant(b_gnt)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int i, input int j);
    if (i == 0) return (j == 0) ? a_rdy0 : a_rdy1;
    return (j == 0) ? b_rdy0 : b_rdy1;
  endfunction

  // Output monitors: compare each delivered beat and check data holds under backpressure.
  logic [DW-1:0] a_prev_od;
  logic          a_prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      a_prev_stall <= 1'b0;
    end else begin
      if (a_prev_stall && a_ov) check("hold_a", a_od, a_prev_od);
      if (a_ov && a_ordy) begin
        check("beat_expected_a", DW'(exp_a.size() != 0), DW'(1));
        if (exp_a.size() != 0) check("data_a", a_od, exp_a.pop_front());
      end
      a_prev_stall <= a_ov && !a_ordy;
      a_prev_od    <= a_od;
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_ov && b_ordy) begin
      check("beat_expected_b", DW'(exp_b.size() != 0), DW'(1));
      if (exp_b.size() != 0) check("data_b", b_od, exp_b.pop_front());
    end
  end

  task automatic step();
    logic acc [2][2];
    @(negedge clk);
    ov_pre_a = a_ov;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) acc[i][j] = sv[i][j] && rdy(i, j);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (acc[i][j]) begin
          if (first_acc[i] < 0) first_acc[i] = cyc;
          last_acc[i] = cyc;
          sent[i][j]++;
          sd[i][j] = base[i][j] + DW'(sent[i][j]);
          if (sent[i][j] >= lim[i][j]) sv[i][j] = 1'b0;
        end
      end
    end
  endtask

  task automatic start_src(input int i, input int j, input int unsigned n,
                           input logic [DW-1:0] b);
    base[i][j] = b;
    sent[i][j] = 0;
    lim[i][j]  = n;
    sd[i][j]   = b;
    sv[i][j]   = (n > 0);
  endtask

  task automatic push_seq(input int q, input logic [DW-1:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      if (q == 0) exp_a.push_back(b + DW'(k));
      else        exp_b.push_back(b + DW'(k));
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      first_acc[i] = -1;
      last_acc[i]  = -1;
      for (int j = 0; j < 2; j++) begin
        sv[i][j] = 1'b0; sd[i][j] = '0; base[i][j] = '0; sent[i][j] = 0; lim[i][j] = 0;
      end
    end
    a_ordy = 1'b1;
    b_ordy = 1'b1;
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_grant"}, DW'(a_gnt), DW'(0));
    check({tag, "_ready0"}, DW'(a_rdy0), DW'(0));
    check({tag, "_ready1"}, DW'(a_rdy1), DW'(0));
    check({tag, "_aso_valid"}, DW'(a_ov), DW'(0));
    check({tag, "_aso_data"}, a_od, DW'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic run(input int i, input int bound);
    for (int c = 0; c < bound; c++) begin
      if (!(sv[i][0] || sv[i][1])) break;
      step();
    end
    check("run_done", DW'(sv[i][0] || sv[i][1]), DW'(0));
  endtask

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      @(negedge clk);
    end
    check("drain_a", DW'(exp_a.size()), DW'(0));
    check("drain_b", DW'(exp_b.size()), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_gnt;

    // Power-on reset values
    clear_inputs();
    reset_n = 1'b0;
    #1;
    chk_rst("por");
    do_reset();

    // Source 0 alone: 41 beats, re-granted every 16 with no bubble
    start_src(0, 0, 41, DW'(0));
    push_seq(0, DW'(0), 41);
    step();
    check("s1_first_accept", DW'(sent[0][0]), DW'(1));
    check("s1_lat_pre", DW'(ov_pre_a), DW'(0));
    check("s1_lat_post", DW'(a_ov), DW'(1));
    bad_gnt = 0;
    for (int c = 0; c < 100 && sv[0][0]; c++) begin
      if (a_gnt != 2'b01) bad_gnt++;
      step();
    end
    check("s1_grant_cycles_not_01", DW'(bad_gnt), DW'(0));
    check("s1_span", DW'(last_acc[0] - first_acc[0]), DW'(40));
    run(0, 10);
    drain();

    // Both sources from reset: 16-beat bursts alternate, source 0 first, no idle
    do_reset();
    start_src(0, 0, 48, DW'('h100));
    start_src(0, 1, 48, DW'('h200));
    for (int b = 0; b < 3; b++) begin
      push_seq(0, DW'('h100 + 16 * b), 16);
      push_seq(0, DW'('h200 + 16 * b), 16);
    end
    step();
    check("s2_first_grant", DW'(a_gnt), DW'(2'b01));
    run(0, 300);
    check("s2_span", DW'(last_acc[0] - first_acc[0]), DW'(95));
    drain();

    // Downstream stalls five cycles mid-burst
    do_reset();
    start_src(0, 0, 20, DW'('h300));
    push_seq(0, DW'('h300), 20);
    repeat (6) step();
    a_ordy = 1'b0;
    repeat (5) step();
    check("s3_stall_ready", DW'(a_rdy0), DW'(0));
    check("s3_stall_valid", DW'(a_ov), DW'(1));
    check("s3_stall_accepted", DW'(sent[0][0]), DW'(7));
    a_ordy = 1'b1;
    run(0, 100);
    drain();

    // Source 1 stops after 3 beats while source 0 waits
    do_reset();
    start_src(0, 1, 3, DW'('h700));
    push_seq(0, DW'('h700), 3);
    push_seq(0, DW'('h800), 5);
    step();
    start_src(0, 0, 5, DW'('h800));
    for (int c = 0; c < 10 && sent[0][1] < 3; c++) step();
    check("s4_src1_beats", DW'(sent[0][1]), DW'(3));
    check("s4_grant_before", DW'(a_gnt), DW'(2'b10));
    @(posedge clk);
    #1;
    check("s4_grant_after", DW'(a_gnt), DW'(2'b01));
    run(0, 50);
    drain();

    // Reset with two beats buffered after source 0 finished a burst
    do_reset();
    a_ordy = 1'b0;
    start_src(0, 0, 2, DW'('h400));
    for (int c = 0; c < 10 && sent[0][0] < 2; c++) step();
    step();
    check("s5_buffered_valid", DW'(a_ov), DW'(1));
    #1 reset_n = 1'b0;
    #1;
    chk_rst("mid");
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    start_src(0, 0, 2, DW'('h500));
    start_src(0, 1, 2, DW'('h600));
    push_seq(0, DW'('h500), 2);
    push_seq(0, DW'('h600), 2);
    step();
    check("s5_tie_grant", DW'(a_gnt), DW'(2'b01));
    check("s5_tie_beat", DW'(sent[0][0]), DW'(1));
    run(0, 50);
    drain();

    // BURST_LEN 1: grant flips every beat at full rate
    do_reset();
    start_src(1, 0, 10, DW'('hA00));
    start_src(1, 1, 10, DW'('hB00));
    for (int k = 0; k < 10; k++) begin
      exp_b.push_back(DW'('hA00 + k));
      exp_b.push_back(DW'('hB00 + k));
    end
    step();
    check("s6_switch_after_one", DW'(b_gnt), DW'(2'b10));
    run(1, 100);
    check("s6_span", DW'(last_acc[1] - first_acc[1]), DW'(19));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
